// File: rtl/supercar_ctrl.sv
// supercar_ctrl: bouncing-light sequencer for an N-LED bar.
// Converts raw button levels into one-cycle press events and runs an
// IDLE/RUN/PAUSE machine that steps a dot or comet across the bar
// at one of four speeds.
//
// Ports:
//   clk, rst        clock, async active-high reset
//   btn_start       press: IDLE->RUN, RUN<->PAUSE
//   btn_stop        press: any state -> IDLE (wins over start)
//   btn_faster      press: speed+1, saturating at 3
//   btn_slower      press: speed-1, saturating at 0
//   wide            1 = three-LED comet, 0 = single dot
//   leds            bar pattern
//   running         high while in RUN
//   speed           current speed level 0..3
//   step_pulse      one-cycle pulse after each position update
module supercar_ctrl #(
    parameter int N_LEDS   = 8,
    parameter int BASE_DIV = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_start,
    input  logic              btn_stop,
    input  logic              btn_faster,
    input  logic              btn_slower,
    input  logic              wide,
    output logic [N_LEDS-1:0] leds,
    output logic              running,
    output logic [1:0]        speed,
    output logic              step_pulse
);

    localparam int PW = $clog2(N_LEDS);
    localparam int CW = $clog2(4 * BASE_DIV + 1);
    localparam logic [PW-1:0] LAST = PW'(N_LEDS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_t;

    state_t state;
    state_t state_nx;

    // Press detectors: previous sample plus registered event per button.
    logic [3:0] btn_raw;
    logic [3:0] btn_prev;
    logic [3:0] btn_ev;
    logic       ev_start;
    logic       ev_stop;
    logic       ev_faster;
    logic       ev_slower;

    logic [PW-1:0] pos;
    logic          dir_up;
    logic [CW-1:0] count;
    logic [CW-1:0] per_m1;
    logic          tick;
    logic          wide_q;

    logic          clr;
    logic          adv;
    logic          cnt_zero;
    logic [N_LEDS-1:0] dot;

    assign btn_raw   = {btn_slower, btn_faster, btn_stop, btn_start};
    assign ev_start  = btn_ev[0];
    assign ev_stop   = btn_ev[1];
    assign ev_faster = btn_ev[2];
    assign ev_slower = btn_ev[3];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev <= '0;
            btn_ev   <= '0;
        end else begin
            btn_prev <= btn_raw;
            btn_ev   <= btn_raw & ~btn_prev;
        end
    end

    // Period minus one for the current speed.
    always_comb begin
        per_m1 = CW'(BASE_DIV * (4 - int'(speed)) - 1);
    end

    // >= so that a speed-up shrinking the period below count steps at once.
    assign tick = (count >= per_m1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (ev_start) state_nx = RUN;
            RUN:     if (ev_start) state_nx = PAUSE;
            PAUSE:   if (ev_start) state_nx = RUN;
            default: state_nx = IDLE;
        endcase
        if (ev_stop) begin
            state_nx = IDLE;
        end
    end

    // Output / control decode
    always_comb begin
        running  = (state == RUN);
        clr      = 1'b0;
        adv      = 1'b0;
        cnt_zero = 1'b0;
        unique case (state)
            IDLE:    clr = 1'b1;
            RUN:     adv = ~ev_start;
            PAUSE:   cnt_zero = ev_start;
            default: clr = 1'b1;
        endcase
        if (ev_stop) begin
            clr      = 1'b1;
            adv      = 1'b0;
            cnt_zero = 1'b0;
        end

        dot  = {{(N_LEDS-1){1'b0}}, 1'b1} << pos;
        leds = '0;
        if (state != IDLE) begin
            // Shifting drops comet bits that fall off either end.
            leds = wide_q ? (dot | (dot << 1) | (dot >> 1)) : dot;
        end
    end

    // Position, direction, period counter and step pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pos        <= '0;
            dir_up     <= 1'b1;
            count      <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= 1'b0;
            if (clr) begin
                pos    <= '0;
                dir_up <= 1'b1;
                count  <= '0;
            end else if (cnt_zero) begin
                count <= '0;
            end else if (adv) begin
                if (tick) begin
                    count      <= '0;
                    step_pulse <= 1'b1;
                    if (dir_up) begin
                        if (pos == LAST) begin
                            dir_up <= 1'b0;
                            pos    <= pos - PW'(1);
                        end else begin
                            pos <= pos + PW'(1);
                        end
                    end else begin
                        if (pos == '0) begin
                            dir_up <= 1'b1;
                            pos    <= PW'(1);
                        end else begin
                            pos <= pos - PW'(1);
                        end
                    end
                end else begin
                    count <= count + CW'(1);
                end
            end
        end
    end

    // Speed and wide register; simultaneous faster/slower cancel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            speed  <= 2'd1;
            wide_q <= 1'b0;
        end else begin
            wide_q <= wide;
            if (ev_faster && !ev_slower && speed != 2'd3) begin
                speed <= speed + 2'd1;
            end else if (ev_slower && !ev_faster && speed != 2'd0) begin
                speed <= speed - 2'd1;
            end
        end
    end

endmodule

// File: tb/tb_supercar_ctrl.sv
// tb_supercar_ctrl: directed and randomized bench for supercar_ctrl
// with a behavioural model compared on every falling edge.
module tb_supercar_ctrl;

    localparam int N  = 8;
    localparam int BD = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   btn = 4'b0;
    logic         wide = 1'b0;
    logic [N-1:0] leds;
    logic         running;
    logic [1:0]   speed;
    logic         step_pulse;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    supercar_ctrl #(.N_LEDS(N), .BASE_DIV(BD)) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_start  (btn[0]),
        .btn_stop   (btn[1]),
        .btn_faster (btn[2]),
        .btn_slower (btn[3]),
        .wide       (wide),
        .leds       (leds),
        .running    (running),
        .speed      (speed),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0 idle, 1 run, 2 pause; dir is +1/-1.
    int       m_mode  = 0;
    int       m_pos   = 0;
    int       m_dir   = 1;
    int       m_cnt   = 0;
    int       m_spd   = 1;
    int       m_pulse = 0;
    bit       m_wide  = 1'b0;
    bit [3:0] m_prev  = 4'b0;
    bit [3:0] m_ev    = 4'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_pos = 0; m_dir = 1; m_cnt = 0;
            m_spd = 1; m_pulse = 0; m_wide = 1'b0;
            m_prev = 4'b0; m_ev = 4'b0;
        end else begin
            automatic int per = BD * (4 - m_spd);
            m_pulse = 0;
            if (m_ev[1]) begin
                m_mode = 0; m_pos = 0; m_dir = 1; m_cnt = 0;
            end else if (m_ev[0] && m_mode == 0) begin
                m_mode = 1; m_pos = 0; m_dir = 1; m_cnt = 0;
            end else if (m_ev[0] && m_mode == 1) begin
                m_mode = 2;
            end else if (m_ev[0] && m_mode == 2) begin
                m_mode = 1; m_cnt = 0;
            end else if (m_mode == 1) begin
                if (m_cnt >= per - 1) begin
                    m_cnt = 0;
                    m_pulse = 1;
                    if (m_pos + m_dir < 0 || m_pos + m_dir > N - 1)
                        m_dir = -m_dir;
                    m_pos = m_pos + m_dir;
                end else begin
                    m_cnt++;
                end
            end
            if (m_ev[2] && !m_ev[3] && m_spd < 3) m_spd++;
            if (m_ev[3] && !m_ev[2] && m_spd > 0) m_spd--;
            m_wide = wide;
            m_ev   = btn & ~m_prev;
            m_prev = btn;
        end
    end

    function automatic logic [N-1:0] exp_leds();
        logic [N-1:0] v = '0;
        if (m_mode != 0)
            for (int i = 0; i < N; i++)
                if (i == m_pos ||
                    (m_wide && (i == m_pos - 1 || i == m_pos + 1)))
                    v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_leds", leds, exp_leds());
            chk("m_running", running, m_mode == 1);
            chk("m_speed", speed, m_spd);
            chk("m_step", step_pulse, m_pulse);
        end
    end

    task automatic tap(int i);
        @(negedge clk) btn[i] = 1'b1;
        @(negedge clk) btn[i] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    int exp_seq[14] = '{2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1};
    int n;
    int pulses;
    int rises;
    bit prev_run;

    initial begin
        #1 rst = 1'b1;
        chk_en = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_leds", leds, 0);
        chk("rst_running", running, 0);
        chk("rst_speed", speed, 1);
        chk("rst_step", step_pulse, 0);

        // Start: latency and first step
        @(negedge clk) btn[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            btn[0] = 1'b0;
            n++;
        end while (!running && n < 10);
        chk("start_lat", n, 2);
        chk("entry_leds", leds, 8'h01);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (leds == 8'h01 && n < 40);
        chk("first_step", n, 12);
        chk("step1_leds", leds, 8'h02);

        // Bounce
        pulses = 0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            n = 0;
            while (!step_pulse && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (step_pulse) pulses++;
            chk("bounce_pos", leds, 32'd1 << exp_seq[i]);
        end
        chk("bounce_pulses", pulses, 14);

        // Speed saturation and cancel
        repeat (5) tap(2);
        chk("spd_max", speed, 3);
        repeat (5) tap(3);
        chk("spd_min", speed, 0);
        tap(2);
        @(negedge clk) begin btn[2] = 1'b1; btn[3] = 1'b1; end
        @(negedge clk) begin btn[2] = 1'b0; btn[3] = 1'b0; end
        repeat (2) @(negedge clk);
        chk("spd_both", speed, 1);

        // Speed-up with count past the new period
        n = 0;
        while (!(m_mode == 1 && m_cnt == 8) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cnt8", n < 100, 1);
        btn[2] = 1'b1;
        @(negedge clk) btn[2] = 1'b0;
        @(negedge clk);
        chk("fast_spd", speed, 2);
        chk("fast_nostep", step_pulse, 0);
        @(negedge clk);
        chk("fast_step", step_pulse, 1);

        // Pause / resume at pos 3 going up
        tap(3);
        n = 0;
        while (!(m_mode == 1 && m_pos == 3 && m_dir == 1 && m_cnt == 0)
               && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wait_pos3", n < 400, 1);
        btn[0] = 1'b1;
        @(negedge clk) btn[0] = 1'b0;
        repeat (30) @(negedge clk);
        chk("pause_run", running, 0);
        chk("pause_leds", leds, 8'h08);
        btn[0] = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            btn[0] = 1'b0;
            n++;
        end while (!running && n < 10);
        chk("resume_lat", n, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (leds == 8'h08 && n < 40);
        chk("resume_step", n, 12);
        chk("resume_leds", leds, 8'h10);

        // Start and stop together in RUN
        @(negedge clk) begin btn[0] = 1'b1; btn[1] = 1'b1; end
        @(negedge clk) begin btn[0] = 1'b0; btn[1] = 1'b0; end
        @(negedge clk);
        chk("stop_run", running, 0);
        chk("stop_leds", leds, 0);

        // Held start gives one entry
        rises = 0;
        prev_run = running;
        btn[0] = 1'b1;
        for (int i = 0; i < 55; i++) begin
            @(negedge clk);
            if (i == 49) btn[0] = 1'b0;
            if (running && !prev_run) rises++;
            prev_run = running;
        end
        chk("hold_entries", rises, 1);

        // Wide comet at the ends and the middle
        tap(1);
        tap(0);
        chk("wide_entry", running, 1);
        wide = 1'b1;
        @(negedge clk);
        chk("wide_p0", leds, 8'h03);
        n = 0;
        while (m_pos != 7 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wide_p7", leds, 8'hC0);
        n = 0;
        while (m_pos != 4 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("wide_p4", leds, 8'h38);
        wide = 1'b0;

        // Async reset mid-period
        n = 0;
        while (!(m_mode == 1 && m_cnt == 5) && n < 100) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_leds", leds, 0);
        chk("arst_running", running, 0);
        chk("arst_speed", speed, 1);
        chk("arst_step", step_pulse, 0);
        @(negedge clk) rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            btn[0] = ($urandom_range(0, 24) == 0);
            btn[1] = ($urandom_range(0, 149) == 0);
            btn[2] = ($urandom_range(0, 29) == 0);
            btn[3] = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 39) == 0) wide = ~wide;
            if ($urandom_range(0, 799) == 0) begin
                #2 rst = 1'b1;
                #1 rst = 1'b0;
            end
        end
        btn = 4'b0;
        @(negedge clk);
        chk_en = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
